time_set_input_ctrl: RTL and testbench



---
 rtl/time_set_input_ctrl.sv | 134 +++++++++++++
 tb/tb_time_set_input_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_input_ctrl.sv
// Debounces the set/hour/min/sec buttons and edits a BCD time, committing it with a one-cycle load strobe.
// Raw press to edge pulse is DEBOUNCE_CYCLES+3 cycles; the FSM reacts on the following edge.
module time_set_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        btn_set,
   input  logic        btn_hour,
   input  logic        btn_min,
   input  logic        btn_sec,
   input  logic [23:0] cur_time,
   output logic [23:0] new_time,
   output logic        load,
   output logic        editing
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] EDIT   = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // bit 0 = set, 1 = hour, 2 = min, 3 = sec
   logic [3:0]       raw;
   logic [3:0]       sync1_q, sync1_d;
   logic [3:0]       sync2_q, sync2_d;
   logic [3:0]       deb_q, deb_d;
   logic [3:0]       deb_dly_q, deb_dly_d;
   logic [3:0]       edge_q, edge_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [1:0]       state_q, state_d;
   logic [23:0]      time_q, time_d;

   assign raw = {btn_sec, btn_min, btn_hour, btn_set};

   always_comb begin
      sync1_d   = raw;
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      deb_dly_d = deb_q;
      edge_d    = deb_q & ~deb_dly_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Hours wrap 23 -> 00; anything not a valid hour also restarts at 00.
   function automatic logic [7:0] inc_hour(input logic [7:0] v);
      logic [7:0] r;
      if (v[7:4] > 4'd2 || v[3:0] > 4'd9 || v >= 8'h23) begin
         r = 8'h00;
      end else if (v[3:0] == 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

   function automatic logic [7:0] inc_min_sec(input logic [7:0] v);
      logic [7:0] r;
      if (v[7:4] > 4'd5 || v[3:0] > 4'd9) begin
         r = 8'h00;
      end else if (v[3:0] < 4'd9) begin
         r = {v[7:4], v[3:0] + 4'd1};
      end else if (v[7:4] < 4'd5) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = 8'h00;
      end
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      case (state_q)
         IDLE: begin
            if (edge_q[0]) begin
               time_d  = cur_time;
               state_d = EDIT;
            end
         end
         EDIT: begin
            if (edge_q[0]) begin
               state_d = COMMIT;
            end else begin
               if (edge_q[1]) time_d[23:16] = inc_hour(time_q[23:16]);
               if (edge_q[2]) time_d[15:8]  = inc_min_sec(time_q[15:8]);
               if (edge_q[3]) time_d[7:0]   = inc_min_sec(time_q[7:0]);
            end
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         edge_q    <= '0;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         state_q   <= IDLE;
         time_q    <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         edge_q    <= edge_d;
         for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
         state_q   <= state_d;
         time_q    <= time_d;
      end
   end

   assign new_time = time_q;
   assign load     = (state_q == COMMIT);
   assign editing  = (state_q == EDIT);

endmodule

// File: tb/tb_time_set_input_ctrl.sv
// Bench for time_set_input_ctrl with a short debounce window; commits are scoreboarded.
module tb_time_set_input_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  btns = 4'b0000;   // bit 0 set, 1 hour, 2 min, 3 sec
   logic [23:0] cur_time = 24'h0;
   logic [23:0] new_time;
   logic        load;
   logic        editing;

   int total = 0;
   int bad   = 0;
   int loads = 0;
   int exp_loads = 0;
   logic [23:0] sb[$];
   logic [23:0] exp_time;
   logic        prev_load = 1'b0;

   time_set_input_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_set  (btns[0]),
      .btn_hour (btns[1]),
      .btn_min  (btns[2]),
      .btn_sec  (btns[3]),
      .cur_time (cur_time),
      .new_time (new_time),
      .load     (load),
      .editing  (editing)
   );

   always #5 clk = ~clk;

   // Decimal reference arithmetic for the BCD fields.
   function automatic logic [7:0] ref_hour(input logic [7:0] v);
      int d;
      d = int'(v[7:4]) * 10 + int'(v[3:0]);
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || d >= 23) return 8'h00;
      d = d + 1;
      return {4'(d / 10), 4'(d % 10)};
   endfunction

   function automatic logic [7:0] ref_ms(input logic [7:0] v);
      int d;
      d = int'(v[7:4]) * 10 + int'(v[3:0]);
      if (v[7:4] > 4'd5 || v[3:0] > 4'd9 || d >= 59) return 8'h00;
      d = d + 1;
      return {4'(d / 10), 4'(d % 10)};
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (prev_load) begin
            total++;
            if (load !== 1'b0) begin
               bad++;
               $display("FAIL load_width: load=%b, required 0 on the cycle after a strobe", load);
            end
         end
         if (load === 1'b1) begin
            loads++;
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_load: new_time=%h, no commit expected", new_time);
            end else begin
               exp_time = sb.pop_front();
               if (new_time !== exp_time) begin
                  bad++;
                  $display("FAIL commit_value: new_time=%h, required %h", new_time, exp_time);
               end
            end
         end
      end
      prev_load = (load === 1'b1) && !reset;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
   endtask

   task automatic press(input int b);
      btns[b] = 1'b1;
      repeat (10) step();
      btns[b] = 1'b0;
      repeat (10) step();
   endtask

   task automatic wait_load(input int prev);
      int n = 0;
      while (loads == prev && n < 40) begin
         step();
         n++;
      end
      total++;
      if (loads == prev) begin
         bad++;
         $display("FAIL load_timeout: no load within 40 cycles, loads=%0d required %0d", loads, prev + 1);
      end
   endtask

   task automatic enter_edit(input logic [23:0] t);
      cur_time = t;
      press(0);
      total++;
      if (editing !== 1'b1) begin
         bad++;
         $display("FAIL enter_edit: editing=%b, required 1", editing);
      end
   endtask

   task automatic commit();
      int prev = loads;
      sb.push_back(exp_time);
      exp_loads++;
      press(0);
      if (loads == prev) wait_load(prev);
      total++;
      if (editing !== 1'b0 || new_time !== exp_time) begin
         bad++;
         $display("FAIL after_commit: editing=%b new_time=%h, required 0 and %h", editing, new_time, exp_time);
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (new_time !== 24'h0) begin bad++; $display("FAIL reset_new_time: %h, required 000000", new_time); end
      total++;
      if (load !== 1'b0) begin bad++; $display("FAIL reset_load: %b, required 0", load); end
      total++;
      if (editing !== 1'b0) begin bad++; $display("FAIL reset_editing: %b, required 0", editing); end
      for (int i = 0; i < 20; i++) begin
         step();
         total++;
         if ({load, editing} !== 2'b00 || new_time !== 24'h0) begin
            bad++;
            $display("FAIL reset_idle: load=%b editing=%b new_time=%h, required 0 0 000000", load, editing, new_time);
         end
      end
   endtask

   task automatic test_glitch();
      btns[0] = 1'b1;
      repeat (3) step();
      btns[0] = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         total++;
         if (editing !== 1'b0) begin
            bad++;
            $display("FAIL glitch_editing: editing=%b, required 0", editing);
         end
      end
   endtask

   task automatic test_edit_wrap();
      int n = 0;
      cur_time = 24'h235959;
      exp_time = 24'h235959;
      btns[0] = 1'b1;
      // Count edges from the first one that samples the press.
      while (editing !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      total++;
      if (n - 1 != 7) begin
         bad++;
         $display("FAIL editing_latency: %0d cycles, required 7", n - 1);
      end
      repeat (10 - n) step();
      btns[0] = 1'b0;
      repeat (10) step();
      press(1); exp_time[23:16] = ref_hour(exp_time[23:16]);
      press(2); exp_time[15:8]  = ref_ms(exp_time[15:8]);
      press(3); exp_time[7:0]   = ref_ms(exp_time[7:0]);
      total++;
      if (editing !== 1'b1 || new_time !== 24'h000000) begin
         bad++;
         $display("FAIL wrap_edit: editing=%b new_time=%h, required 1 000000", editing, new_time);
      end
      commit();
      repeat (10) step();
      total++;
      if (new_time !== 24'h000000) begin
         bad++;
         $display("FAIL held_idle: new_time=%h, required 000000", new_time);
      end
   endtask

   task automatic test_multi();
      exp_time = 24'h094509;
      enter_edit(24'h094509);
      cur_time = 24'h111111;
      press(1); exp_time[23:16] = ref_hour(exp_time[23:16]);
      for (int i = 0; i < 15; i++) begin
         press(2);
         exp_time[15:8] = ref_ms(exp_time[15:8]);
      end
      press(3); exp_time[7:0] = ref_ms(exp_time[7:0]);
      total++;
      if (exp_time !== 24'h100010 || new_time !== exp_time) begin
         bad++;
         $display("FAIL multi_edit: new_time=%h model=%h, required 100010", new_time, exp_time);
      end
      commit();
   endtask

   task automatic test_back_to_back();
      int prev;
      exp_time = 24'h121314;
      enter_edit(24'h121314);
      prev = loads;
      sb.push_back(exp_time);
      exp_loads++;
      btns = 4'b0101;
      repeat (10) step();
      btns = 4'b0000;
      repeat (10) step();
      if (loads == prev) wait_load(prev);
      total++;
      if (new_time !== 24'h121314 || editing !== 1'b0) begin
         bad++;
         $display("FAIL set_with_min: new_time=%h editing=%b, required 121314 0", new_time, editing);
      end
   endtask

   task automatic test_reset_mid_edit();
      int prev;
      exp_time = 24'h050000;
      enter_edit(24'h050000);
      press(1);
      press(1);
      total++;
      if (new_time !== 24'h070000) begin
         bad++;
         $display("FAIL hour_twice: new_time=%h, required 070000", new_time);
      end
      prev = loads;
      do_reset();
      total++;
      if (new_time !== 24'h0 || editing !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_edit: new_time=%h editing=%b, required 000000 0", new_time, editing);
      end
      repeat (10) step();
      total++;
      if (loads != prev) begin
         bad++;
         $display("FAIL reset_no_load: loads=%0d, required %0d", loads, prev);
      end
      exp_time = 24'h225858;
      enter_edit(24'h225858);
      press(1); exp_time[23:16] = ref_hour(exp_time[23:16]);
      press(2); exp_time[15:8]  = ref_ms(exp_time[15:8]);
      press(3); exp_time[7:0]   = ref_ms(exp_time[7:0]);
      press(3); exp_time[7:0]   = ref_ms(exp_time[7:0]);
      commit();
      total++;
      if (new_time !== 24'h235900) begin
         bad++;
         $display("FAIL post_reset_edit: new_time=%h, required 235900", new_time);
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_edit_wrap();
      test_multi();
      test_back_to_back();
      test_reset_mid_edit();
      repeat (5) step();
      total++;
      if (loads != exp_loads || sb.size() != 0) begin
         bad++;
         $display("FAIL load_count: loads=%0d pending=%0d, required %0d and 0", loads, sb.size(), exp_loads);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
